// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, AES-128 sizes and GF(2^8) helpers
// used by the key schedule and the MixColumns blocks.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_BITS   = 128;
  localparam int SCHED_BITS = KEY_BITS * (NUM_ROUNDS + 1);

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] GF_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_expansion_seq_if.sv
// Load/result bundle between the decryption controller and the key schedule.
interface key_expansion_seq_if;

  logic                            start;
  logic [aes_pkg::KEY_BITS-1:0]    keyIn;
  logic [aes_pkg::SCHED_BITS-1:0]  roundKeys;
  logic                            busy;
  logic                            keysValid;

  modport master (
    output start, keyIn,
    input  roundKeys, busy, keysValid
  );

  modport slave (
    input  start, keyIn,
    output roundKeys, busy, keysValid
  );

endinterface

// File: rtl/SubBytes_sbox.sv
// Combinational AES forward S-box for one byte; shared with the encryption SubBytes stage.
module SubBytes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry 0 sits in the most significant byte, so byte a starts at bit 8*(255-a) = {~a, 3'b0}
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock into a packed 11-slot register,
// held until the next load so the decryption key-addition stage can index any round.
module key_expansion_seq
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    key_expansion_seq_if.slave  bus
);

    ks_state_e               state, next_state;
    logic [3:0]              rnd;
    logic [7:0]              rcon;
    logic [SCHED_BITS-1:0]   round_keys;
    logic                    load, expand;

    logic [3:0]              prev_slot;
    logic [KEY_BITS-1:0]     prev_key;
    logic [31:0]             p0, p1, p2, p3;
    logic [31:0]             rot_word, sub_word, t;
    logic [31:0]             w0, w1, w2, w3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        expand     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = EXPAND;
                end
            end
            EXPAND: begin
                expand = 1'b1;
                if (rnd == 4'(NUM_ROUNDS)) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // rnd is 0 only outside EXPAND; clamp so the read select never leaves the schedule
    assign prev_slot = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
    assign prev_key  = round_keys[{prev_slot, 7'b0} +: KEY_BITS];
    assign {p0, p1, p2, p3} = prev_key;
    assign rot_word  = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        SubBytes_sbox u_sbox (
            .a (rot_word[8*g +: 8]),
            .y (sub_word[8*g +: 8])
        );
    end

    assign t  = sub_word ^ {rcon, 24'h0};
    assign w0 = p0 ^ t;
    assign w1 = p1 ^ w0;
    assign w2 = p2 ^ w1;
    assign w3 = p3 ^ w2;

    // NOTE: the schedule register is reset because the consumer reads it as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_keys <= '0;
            rnd        <= 4'd0;
            rcon       <= 8'h01;
        end else if (load) begin
            round_keys[KEY_BITS-1:0] <= bus.keyIn;
            rnd                      <= 4'd1;
            rcon                     <= 8'h01;
        end else if (expand) begin
            round_keys[{rnd, 7'b0} +: KEY_BITS] <= {w0, w1, w2, w3};
            if (rnd != 4'(NUM_ROUNDS)) begin
                rnd  <= rnd + 4'd1;
                rcon <= xtime(rcon);
            end
        end
    end

    assign bus.roundKeys = round_keys;
    assign bus.busy      = (state == EXPAND);
    assign bus.keysValid = (state == DONE);

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: stimulus queues expected schedules, a monitor
// compares them when keysValid rises, using FIPS-197 A.1 and all-zero key vectors.
module tb_key_expansion_seq;

    typedef struct {
        logic [127:0] rk0;
        logic [127:0] rk1;
        logic [127:0] rk10;
        int           start_cyc;
    } exp_t;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z   = 128'h0;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

    key_expansion_seq_if bus();

    key_expansion_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] slot(input int i);
        logic [1407:0] rk;
        rk = bus.roundKeys;
        return rk[128*i +: 128];
    endfunction

    // Monitor: pop an expectation whenever a schedule becomes valid
    always @(negedge clk) begin
        check("busy_valid_exclusive", 128'(bus.busy & bus.keysValid), 128'(0));
        if (bus.keysValid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("latency", 128'(cyc - e.start_cyc), 128'(10));
                check("slot0", slot(0), e.rk0);
                check("slot1", slot(1), e.rk1);
                check("slot10", slot(10), e.rk10);
            end
        end
        prev_valid = bus.keysValid;
    end

    task automatic issue(input logic [127:0] key, input logic [127:0] rk1, input logic [127:0] rk10);
        @(negedge clk);
        bus.start = 1'b1;
        bus.keyIn = key;
        exp_q.push_back('{rk0: key, rk1: rk1, rk10: rk10, start_cyc: cyc + 1});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.keysValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.keysValid) check("valid_timeout", 128'(bus.keysValid), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.keyIn = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(bus.busy), 128'(0));
        check("reset_valid", 128'(bus.keysValid), 128'(0));
        check("reset_roundkeys", 128'(|bus.roundKeys), 128'(0));
        rst = 1'b0;

        // FIPS-197 A.1
        issue(KEY_A1, A1_RK1, A1_RK10);
        check("busy_after_start", 128'(bus.busy), 128'(1));
        check("slot0_after_start", slot(0), KEY_A1);
        wait_valid();

        // Back-to-back from DONE: zero key, then A.1 again
        issue(KEY_Z, Z_RK1, Z_RK10);
        check("valid_drops_on_restart", 128'(bus.keysValid), 128'(0));
        wait_valid();
        issue(KEY_A1, A1_RK1, A1_RK10);
        wait_valid();

        // start during EXPAND is ignored
        issue(KEY_Z, Z_RK1, Z_RK10);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.keyIn = KEY_A1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid();

        // Reset in the middle of an expansion
        issue(KEY_A1, A1_RK1, A1_RK10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_busy", 128'(bus.busy), 128'(0));
        check("midreset_valid", 128'(bus.keysValid), 128'(0));
        check("midreset_roundkeys", 128'(|bus.roundKeys), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(KEY_A1, A1_RK1, A1_RK10);
        wait_valid();

        // Key-addition stage with count = 10 and data = 0 yields round key 10
        check("keyadd_round10", 128'h0 ^ slot(10), A1_RK10);

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Iterative AES-128 key schedule that expands a 128-bit cipher key into the 11 round keys consumed by the key-addition stage of the decryption datapath. It sits directly upstream of the decryption key-addition block: its packed round-key bus drives that block's `roundKeys` input, and the datapath controller may begin decryption once `keysValid` is high. The block produces one round key per clock and holds the full schedule until the next key load.

## Interface
- No parameters. Sizes are fixed by AES-128: Nk = 4, Nr = 10, 11 round keys.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle load request; `keyIn` is sampled on the same edge.
- `keyIn` input 128: cipher key, FIPS-197 byte order; w0 = `keyIn[127:96]`.
- `roundKeys` output 1408: packed schedule; round key i occupies `[128*i+127 : 128*i]`; i = 0 is the cipher key, i = 10 is the last round key.
- `busy` output 1: expansion in progress.
- `keysValid` output 1: all 11 round keys are stable and correct.

## Operation
- States are IDLE, EXPAND and DONE.
- IDLE or DONE with `start`=1:
  - write `keyIn` to slot 0;
  - set round counter `rnd` = 1;
  - set Rcon = 8'h01;
  - go to EXPAND.
- EXPAND, each cycle: with previous key words p0..p3 taken from slot `rnd`-1:
  - t = SubWord(RotWord(p3)) ^ {Rcon, 24'h0};
  - w0 = p0^t, w1 = p1^w0, w2 = p2^w1, w3 = p3^w2;
  - write {w0,w1,w2,w3} to slot `rnd`;
  - `rnd` += 1;
  - Rcon = xtime(Rcon): shift left by 1 and XOR with 8'h1b when the carry-out is set. The sequence is 01,02,04,08,10,20,40,80,1b,36.
- EXPAND with `rnd`=10: after writing slot 10, go to DONE.
- DONE: hold all slots. `keysValid`=1 and `busy`=0.
- `start` during EXPAND is ignored. There is no restart and no queueing.
- `start` in DONE begins a new expansion. `keysValid` falls on that edge.
- Slots not yet written in the current expansion keep their prior contents. They are don't-care while `keysValid`=0.
- `rnd` is 4 bits and never exceeds 10. Rcon is 8 bits.

## Timing
- Reset values:
  - state = IDLE;
  - `roundKeys` = 0;
  - `busy` = 0;
  - `keysValid` = 0;
  - `rnd` = 0;
  - Rcon = 8'h01.
- Reset asserted mid-expansion returns to IDLE immediately and clears all outputs. No partial schedule is flagged valid.
- Let E0 be the edge that samples `start`=1.
  - After E0: slot 0 = key, `busy`=1, `keysValid`=0.
  - Edge E(i), for i = 1..10, writes slot i.
  - After E10: `busy`=0 and `keysValid`=1.
  - Latency from the start edge to valid is 10 cycles.
- Outputs are registered. There is no combinational path from `start` or `keyIn` to any output.
- `busy` and `keysValid` are never both 1.

## Structure
- Shared package `aes_pkg` holds:
  - the state enum (IDLE, EXPAND, DONE);
  - the constants NUM_ROUNDS = 10 and KEY_BITS = 128;
  - the 8'h1b reduction constant, shared with the MixColumns blocks.
- Sub-module `SubBytes_sbox`: combinational 8-bit forward S-box, instantiated 4 times for SubWord. It is the same S-box used by the encryption SubBytes stage.
- The schedule storage is a single 1408-bit register. Writes are indexed by `rnd`.

## Test plan
- FIPS-197 A.1: pulse `start` with `keyIn` = 2b7e151628aed2a6abf7158809cf4f3c.
  - After 10 cycles, `keysValid`=1.
  - Round key 1 = a0fafe1788542cb123a339392a6c7605.
  - Round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - Round key 1 = 62636363626363636263636362636363.
  - Round key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `start` asserted at cycle 4 of an expansion with a different key:
  - The pulse is ignored.
  - The schedule matches the first key.
  - `keysValid` rises at the original time.
- Reset pulsed at cycle 6 of an expansion:
  - Outputs go to 0 immediately.
  - A fresh `start` with the A.1 key yields correct keys 10 cycles later.
- Back-to-back: in DONE, load the zero key and then, after valid, the A.1 key.
  - `keysValid` drops for exactly 10 cycles.
  - The final slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Integration: feed `roundKeys` to the decryption key-addition block with count = 10 and data = 0.
  - Output equals round key 10.
